// File: rtl/ff_ops_pkg.sv
// ff_ops_pkg: op encodings and FSM states for the shared register arbiter
package ff_ops_pkg;
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or after ptr wins
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             any,
  output logic [PW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);
  // walk backwards so the candidate closest to ptr is written last
  always_comb begin
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) idx = PW'((int'(ptr) + k) % N_REQ);
    end
  end
  assign any    = |req;
  assign onehot = any ? {{(N_REQ-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin req/gnt/ack access to one shared JK-style register
module shared_reg_arbiter
  import ff_ops_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] arg,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       reg_q,
  output logic                   busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t state, state_d;
  logic [PW-1:0] ptr, win, pick_idx;
  logic any;
  logic [N_REQ-1:0] pick_oh, gnt_d, ack_d;
  logic [1:0] cap_op;
  logic [WIDTH-1:0] cap_arg, reg_d;
  logic take;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .any(any),
    .idx(pick_idx),
    .onehot(pick_oh)
  );
  assign take = state == ST_IDLE && any;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ack   <= '0;
      ptr   <= '0;
      reg_q <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      ack   <= ack_d;
      if (take) ptr <= pick_idx == PW'(N_REQ - 1) ? '0 : pick_idx + 1'b1;
      if (state == ST_EXEC) reg_q <= reg_d;
    end
  end
  // operands are frozen at the grant edge; later op/arg changes are ignored
  always_ff @(posedge clk) begin
    if (take) begin
      win     <= pick_idx;
      cap_op  <= op[2*pick_idx +: 2];
      cap_arg <= arg[WIDTH*pick_idx +: WIDTH];
    end
  end
  always_comb begin
    state_d = state == ST_IDLE ? (any ? ST_EXEC : ST_IDLE)
            : state == ST_EXEC ? ST_WAIT
            : state == ST_WAIT ? (req[win] ? ST_WAIT : ST_IDLE)
            : ST_IDLE;
  end
  always_comb begin
    gnt_d = take ? pick_oh : '0;
    ack_d = state == ST_EXEC ? gnt : '0;
    reg_d = cap_op == OP_LOAD  ? cap_arg
          : cap_op == OP_SET   ? reg_q | cap_arg
          : cap_op == OP_CLEAR ? reg_q & ~cap_arg
          : reg_q ^ cap_arg;
    busy  = state != ST_IDLE;
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed stimulus with a queue scoreboard on gnt/ack
module tb_shared_reg_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] op = '0;
  logic [31:0] arg = '0;
  logic [3:0] gnt, ack;
  logic [7:0] reg_q;
  logic busy;
  int pass = 0;
  int total = 0;
  logic [3:0] exp_gnt[$];
  logic [11:0] exp_ack[$];

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op), .arg(arg),
    .gnt(gnt), .ack(ack), .reg_q(reg_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (gnt != 0 || ack != 0) chk("onehot", 32'($onehot0(gnt) && $onehot0(ack)), 32'd1);
    if (gnt != 0) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
      else chk("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
    end
    if (ack != 0) begin
      if (exp_ack.size() == 0) chk("ack_unexpected", 32'({ack, reg_q}), 32'd0);
      else chk("ack_reg", 32'({ack, reg_q}), 32'(exp_ack.pop_front()));
    end
  end

  task automatic set_op(input int i, input logic [1:0] o, input logic [7:0] a);
    op[2*i +: 2] = o;
    arg[8*i +: 8] = a;
  endtask

  task automatic expect_op(input logic [3:0] g, input logic [7:0] r);
    exp_gnt.push_back(g);
    exp_ack.push_back({g, r});
  endtask

  task automatic wait_ack(input int i);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ack[i]) return;
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // four-phase requesters: drop on ack, re-raise while grants remain
  task automatic drive(input logic [3:0] raise, input int reps);
    int cnt[4];
    for (int i = 0; i < 4; i++) cnt[i] = raise[i] ? reps : 0;
    req = req | raise;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (ack[i] && cnt[i] > 0) begin
          cnt[i]--;
          req[i] = 1'b0;
        end else if (!req[i] && cnt[i] > 0) req[i] = 1'b1;
      end
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) return;
    end
    chk("drive_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg", 32'(reg_q), 32'h0);
    chk("rst_gnt_ack", 32'({gnt, ack}), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    // single LOAD then all ops on A5
    set_op(2, 2'b00, 8'hA5);
    expect_op(4'b0100, 8'hA5);
    drive(4'b0100, 1);
    @(posedge clk); #1;
    chk("busy_drop", 32'(busy), 32'd0);
    set_op(0, 2'b11, 8'hFF);
    expect_op(4'b0001, 8'h5A);
    drive(4'b0001, 1);
    wait_idle();
    set_op(1, 2'b10, 8'h0F);
    expect_op(4'b0010, 8'h50);
    drive(4'b0010, 1);
    wait_idle();
    set_op(3, 2'b01, 8'h03);
    expect_op(4'b1000, 8'h53);
    drive(4'b1000, 1);
    wait_idle();
    chk("ops_reg", 32'(reg_q), 32'h53);
    // reset while parked in WAIT
    set_op(1, 2'b00, 8'h77);
    expect_op(4'b0010, 8'h77);
    req[1] = 1'b1;
    wait_ack(1);
    do_reset();
    chk("mid_rst_reg", 32'(reg_q), 32'h0);
    chk("mid_rst_gnt_ack", 32'({gnt, ack}), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 1; i < 4; i++) set_op(i, 2'b01, 8'(1 << i));
    expect_op(4'b0010, 8'h02);
    expect_op(4'b0100, 8'h06);
    expect_op(4'b1000, 8'h0E);
    drive(4'b1110, 1);
    wait_idle();
    // full contention from ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 2'b01, 8'(1 << i));
    expect_op(4'b0001, 8'h01);
    expect_op(4'b0010, 8'h03);
    expect_op(4'b0100, 8'h07);
    expect_op(4'b1000, 8'h0F);
    drive(4'b1111, 1);
    wait_idle();
    chk("contend_reg", 32'(reg_q), 32'h0F);
    // fairness between 0 and 3
    set_op(0, 2'b11, 8'h10);
    set_op(3, 2'b11, 8'h80);
    expect_op(4'b0001, 8'h1F);
    expect_op(4'b1000, 8'h9F);
    expect_op(4'b0001, 8'h8F);
    expect_op(4'b1000, 8'h0F);
    drive(4'b1001, 2);
    wait_idle();
    // hog on requester 1 stalls requester 2
    set_op(1, 2'b01, 8'h00);
    expect_op(4'b0010, 8'h0F);
    req[1] = 1'b1;
    wait_ack(1);
    set_op(2, 2'b10, 8'h01);
    expect_op(4'b0100, 8'h0E);
    req[2] = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("hog_stall", 32'({gnt, busy}), 32'h1);
    end
    req[1] = 1'b0;
    drive(4'b0100, 1);
    wait_idle();
    chk("hog_reg", 32'(reg_q), 32'h0E);
    // reset on the EXEC edge discards the captured LOAD
    set_op(0, 2'b00, 8'h3C);
    exp_gnt.push_back(4'b0001);
    req[0] = 1'b1;
    for (int c = 0; c < 20 && !gnt[0]; c++) begin
      @(posedge clk); #1;
    end
    chk("exec_gnt_seen", 32'(gnt[0]), 32'd1);
    reset_n = 1'b0;
    req = '0;
    @(posedge clk); #1;
    chk("exec_rst_ack", 32'(ack), 32'h0);
    chk("exec_rst_reg", 32'(reg_q), 32'h0);
    chk("exec_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("exec_rst_after", 32'({ack, reg_q, 3'b0, busy}), 32'h0);
    chk("gnt_q_empty", 32'(exp_gnt.size()), 32'd0);
    chk("ack_q_empty", 32'(exp_ack.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
